// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM front end: bus widths, FSM encoding and
// the width of the strobe-phase down-counter.
package sram_ctrl_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counter holds ACCESS_CYCLES-1 down to 0, never narrower than one bit.
  function automatic int access_cnt_w(input int cycles);
    return (cycles <= 32'sd2) ? 32'sd1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin grant: on contention the port that was not served
// last wins; a lone requester always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt
);

  // grant decision
  always_comb begin
    gnt_valid = req0 | req1;
    gnt       = 1'b0;
    if (req0 && req1) begin
      gnt = ~last_grant;
    end else if (req1) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-client front end for the 8K x 8 asynchronous SRAM: round-robin grant,
// setup/strobe/hold sequencing and per-client read-data return.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_re,
  output logic              sram_we,
  inout  wire  [DATA_W-1:0] sram_data
);

  localparam int CNT_W = access_cnt_w(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              last_grant_r;
  logic              gnt_valid_s, gnt_s;
  logic              load_s, capture_s;
  logic              sel_we_s, wr_next_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  logic              port_r, wr_r, drive_r, re_r, we_r;
  logic              ack0_r, ack1_r, busy_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata0_r, rdata1_r;

  rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_r),
    .gnt_valid  (gnt_valid_s),
    .gnt        (gnt_s)
  );

  // winner's request fields
  always_comb begin
    sel_we_s    = we0;
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    if (gnt_s) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // next-state and strobe-phase counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_s = ST_SETUP;
          load_s  = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
        cnt_s   = CNT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_HOLD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      ST_HOLD: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    wr_next_s = load_s ? sel_we_s : wr_r;
    capture_s = (state_r == ST_ACCESS) && (state_s == ST_HOLD) && !wr_r;
  end

  // Outputs are derived from the next state so every pin changes on the
  // edge that enters the phase, keeping strobes and address/data apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      last_grant_r <= 1'b1;
      port_r       <= 1'b0;
      wr_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      drive_r      <= 1'b0;
      re_r         <= 1'b0;
      we_r         <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
      rdata0_r     <= {DATA_W{1'b0}};
      rdata1_r     <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (load_s) begin
        port_r       <= gnt_s;
        wr_r         <= sel_we_s;
        addr_r       <= sel_addr_s;
        wdata_r      <= sel_wdata_s;
        last_grant_r <= gnt_s;
      end
      busy_r  <= (state_s != ST_IDLE);
      re_r    <= (state_s == ST_ACCESS) && !wr_r;
      we_r    <= (state_s == ST_ACCESS) && wr_r;
      drive_r <= (state_s != ST_IDLE) && wr_next_s;
      ack0_r  <= (state_s == ST_HOLD) && !port_r;
      ack1_r  <= (state_s == ST_HOLD) && port_r;
      if (capture_s && !port_r) begin
        rdata0_r <= sram_data;
      end
      if (capture_s && port_r) begin
        rdata1_r <= sram_data;
      end
    end
  end

  assign sram_data = drive_r ? wdata_r : {DATA_W{1'bz}};
  assign sram_addr = addr_r;
  assign sram_re   = re_r;
  assign sram_we   = we_r;
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter at ACCESS_CYCLES = 2, 1 and 4: directed scenarios
// followed by random client traffic, checked against a transaction-timeline model.
module tb_sram_arbiter;
  import sram_ctrl_pkg::*;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [7:0]  data;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done [3];

  task automatic chk(input string name, input int inst, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cycle=%0d actual=%0h expected=%0h", name, inst, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int N          = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int LIT_LAT    = (g == 0) ? 4 : ((g == 1) ? 3 : 6);
    localparam int LIT_STROBE = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int RST_K      = (g == 1) ? 2 : 3;

    logic        rst;
    logic [1:0]  req, we;
    logic [12:0] addr [2];
    logic [7:0]  wdata [2];
    logic        ack0, ack1, busy, sram_re, sram_we;
    logic [7:0]  rdata0, rdata1;
    logic [12:0] sram_addr;
    wire  [7:0]  sram_data;

    logic [7:0]  mem  [0:8191];
    logic [7:0]  mmem [0:8191];
    op_t         q0 [$];
    op_t         q1 [$];

    sram_arbiter #(.ACCESS_CYCLES(N)) dut (
      .clk(clk), .reset(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we), .sram_data(sram_data)
    );

    assign sram_data = sram_re ? mem[sram_addr] : 8'bzzzzzzzz;
    always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_data;

    initial begin : run
      int cyc, ph, k, t0, port, lat_start, strobes, rst_chk, rnd_end;
      bit active, idle_now, exp_re, exp_we, exp_hold;
      bit last;
      bit [1:0] pend;
      op_t cur [2];
      op_t mop, op;
      logic [7:0] mrd [2];
      logic [12:0] maddr;
      int order [$];
      int exp_order [6];
      exp_order = '{0, 1, 0, 1, 0, 1};
      for (int i = 0; i < 8192; i++) begin
        mem[i]  = 8'h00;
        mmem[i] = 8'h00;
      end
      rst = 1'b1; req = 2'b00; we = 2'b00;
      addr[0] = 13'd0; addr[1] = 13'd0; wdata[0] = 8'd0; wdata[1] = 8'd0;
      cur[0] = '0; cur[1] = '0; mop = '0;
      cyc = 0; ph = 0; t0 = 0; port = 0; lat_start = 0; strobes = 0;
      rst_chk = -1; rnd_end = 0;
      active = 1'b0; last = 1'b1; pend = 2'b00; maddr = 13'd0;
      mrd[0] = 8'd0; mrd[1] = 8'd0;
      while (ph < 9) begin
        @(negedge clk);
        cyc++;
        // expected outputs of this cycle from the current transaction's timeline
        k        = cyc - t0;
        idle_now = !active;
        exp_re   = active && !mop.we && k >= 2 && k <= N + 1;
        exp_we   = active && mop.we && k >= 2 && k <= N + 1;
        exp_hold = active && k == N + 2;
        if (exp_hold && mop.we) mmem[mop.addr] = mop.data;
        if (exp_hold && !mop.we) mrd[port] = mmem[mop.addr];
        chk("busy", g, cyc, busy, active);
        chk("sram_addr", g, cyc, sram_addr, maddr);
        chk("sram_re", g, cyc, sram_re, exp_re);
        chk("sram_we", g, cyc, sram_we, exp_we);
        chk("ack0", g, cyc, ack0, exp_hold && port == 0);
        chk("ack1", g, cyc, ack1, exp_hold && port == 1);
        chk("rdata0", g, cyc, rdata0, mrd[0]);
        chk("rdata1", g, cyc, rdata1, mrd[1]);
        if (active && mop.we) chk("write_bus", g, cyc, sram_data, mop.data);
        if (exp_re) chk("read_bus", g, cyc, sram_data, mmem[mop.addr]);

        // literal expectations
        if (cyc == 1) begin
          chk("lit_reset_busy", g, cyc, busy, 0);
          chk("lit_reset_addr", g, cyc, sram_addr, 0);
          chk("lit_reset_rdata0", g, cyc, rdata0, 0);
        end
        if (ph == 1 && sram_we) strobes++;
        if (ph == 1 && ack0) begin
          chk("lit_ack_latency", g, cyc, cyc - lat_start, LIT_LAT);
          chk("lit_strobe_width", g, cyc, strobes, LIT_STROBE);
          chk("lit_ack1_quiet", g, cyc, ack1, 0);
        end
        if (ph == 3 && ack0) begin
          chk("lit_xport_rdata0", g, cyc, rdata0, 8);
          chk("lit_xport_rdata1", g, cyc, rdata1, 0);
        end
        if (ph == 4 && (ack0 || ack1)) order.push_back(ack1 ? 1 : 0);
        if (ph == 5 && ack0 && !cur[0].we) chk("lit_overwrite", g, cyc, rdata0, 6);
        if (cyc == rst_chk) begin
          chk("lit_rst_busy", g, cyc, busy, 0);
          chk("lit_rst_we", g, cyc, sram_we, 0);
          chk("lit_rst_ack1", g, cyc, ack1, 0);
        end
        if (ph == 7 && ack0) chk("lit_untouched", g, cyc, rdata0, 5);

        if (exp_hold) active = 1'b0;

        // client and scenario driver
        rst = (cyc < 2);
        if (ph == 6 && active && port == 1 && (cyc - t0) == RST_K) begin
          rst = 1'b1;
          rst_chk = cyc + 1;
        end
        if (pend[0] && ack0) pend[0] = 1'b0;
        if (pend[1] && ack1) pend[1] = 1'b0;
        if (rst) pend = 2'b00;
        if (!rst && !active && pend == 2'b00 && q0.size() == 0 && q1.size() == 0
            && !(ph == 8 && cyc < rnd_end)) begin
          ph++;
          case (ph)
            1: q0.push_back('{1'b1, 13'd0, 8'd5});
            2: q1.push_back('{1'b1, 13'd1, 8'd8});
            3: q0.push_back('{1'b0, 13'd1, 8'd0});
            4: begin
              rst = 1'b1;
              q0.push_back('{1'b0, 13'd0, 8'd0});
              q0.push_back('{1'b0, 13'd1, 8'd0});
              q0.push_back('{1'b1, 13'd2, 8'd3});
              q1.push_back('{1'b1, 13'd1, 8'd6});
              q1.push_back('{1'b0, 13'd0, 8'd0});
              q1.push_back('{1'b1, 13'd3, 8'd4});
            end
            5: begin
              chk("lit_order_len", g, cyc, order.size(), 6);
              if (order.size() == 6)
                for (int i = 0; i < 6; i++) chk("lit_ack_order", g, cyc, order[i], exp_order[i]);
              q0.push_back('{1'b1, 13'd1, 8'd8});
              q0.push_back('{1'b1, 13'd1, 8'd6});
              q0.push_back('{1'b0, 13'd1, 8'd0});
            end
            6: q1.push_back('{1'b1, 13'h1fff, 8'haa});
            7: q0.push_back('{1'b0, 13'd0, 8'd0});
            8: rnd_end = cyc + 400;
            default: ;
          endcase
        end
        if (ph == 8 && cyc < rnd_end) begin
          for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 2) == 0) begin
              op.we   = 1'($urandom_range(0, 1));
              op.addr = 13'($urandom_range(0, 15));
              op.data = 8'($urandom);
              if (p == 0 && q0.size() == 0) q0.push_back(op);
              if (p == 1 && q1.size() == 0) q1.push_back(op);
            end
          end
        end
        if (!rst && !pend[0] && q0.size() > 0) begin
          cur[0] = q0.pop_front();
          pend[0] = 1'b1;
          if (ph == 1) lat_start = cyc;
        end
        if (!rst && !pend[1] && q1.size() > 0) begin
          cur[1] = q1.pop_front();
          pend[1] = 1'b1;
        end
        req = pend;
        we = {cur[1].we, cur[0].we};
        for (int p = 0; p < 2; p++) begin
          addr[p]  = cur[p].addr;
          wdata[p] = cur[p].data;
        end

        // model: reset, or start a transaction in an idle cycle
        if (rst) begin
          active = 1'b0; last = 1'b1; maddr = 13'd0;
          mrd[0] = 8'd0; mrd[1] = 8'd0;
        end else if (idle_now && req != 2'b00) begin
          port   = (req == 2'b11) ? (last ? 0 : 1) : (req[0] ? 0 : 1);
          last   = (port == 1);
          active = 1'b1;
          t0     = cyc;
          mop    = cur[port];
          maddr  = mop.addr;
        end
      end
      done[g] = 1'b1;
    end
  end

  initial begin
    repeat (20000) begin
      @(posedge clk);
      if (done[0] && done[1] && done[2]) break;
    end
    chk("completion", 0, 0, {29'd0, done[2], done[1], done[0]}, 32'd7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Synchronous two-requester front end for the 8K x 8 asynchronous SRAM (13-bit address, RE/WE strobes, 8-bit bidirectional data bus). It grants the SRAM to one of two clients with round-robin fairness. It also sequences each access as setup, strobe and hold phases so that address and data are stable around every RE/WE pulse, and returns read data and a one-cycle acknowledge to the granted client.

## Interface
- ACCESS_CYCLES, 2: cycles RE/WE are held high per access; legal range >= 1.
- ADDR_W, 13: SRAM address width; fixed by the SRAM.
- DATA_W, 8: SRAM data width; fixed by the SRAM.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  request from client 0 / 1.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  target address.
- wdata0 / wdata1  in  DATA_W  write data.
- ack0 / ack1  out  1  one-cycle pulse: transaction complete.
- rdata0 / rdata1  out  DATA_W  last read result for that client.
- busy  out  1  high in every state except IDLE.
- sram_addr  out  ADDR_W  SRAM address.
- sram_re  out  1  SRAM read strobe, active-high.
- sram_we  out  1  SRAM write strobe, active-high.
- sram_data  inout  DATA_W  SRAM data bus; driven only during writes, Z otherwise.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE: if any req is high, pick a winner and latch its we/addr/wdata into internal registers, then go to SETUP. Otherwise stay.
- SETUP: 1 cycle. sram_addr is valid, both strobes are 0, and sram_data is driven with wdata if the access is a write.
- ACCESS: ACCESS_CYCLES cycles, counted by a down-counter. sram_re=1 for a read or sram_we=1 for a write.
  - On the last ACCESS edge of a read, sram_data is captured into the winner's rdata.
- HOLD: 1 cycle. Strobes are 0; address and write data are still driven. The winner's ack=1. Next state is always IDLE.
- Arbitration: round-robin using a last_grant register, which resets to 1.
  - If both req are high in IDLE, the port not equal to last_grant wins.
  - If only one req is high, that port wins.
  - last_grant updates on entry to SETUP.
- Handshake:
  - A client holds req and its fields until ack.
  - It must drop req in the cycle after ack, or keep it high to issue a new request with new fields.
  - A req that is high in IDLE is always treated as a new request.
- rdata0/rdata1 change only on a read completed for that port. Writes and the other port's traffic leave them unchanged.
- Invariants:
  - sram_re and sram_we are never high together.
  - A strobe never rises or falls in the same cycle as an address or data change.
  - sram_data is Z during every read and in IDLE.

## Timing
- Reset values: state IDLE, sram_addr=0, sram_re=0, sram_we=0, sram_data=Z, ack0=ack1=0, rdata0=rdata1=0, busy=0, last_grant=1.
- All outputs are registered. No combinational path runs from req to the sram_* outputs.
- Latency: with req sampled in IDLE at cycle 0, SETUP is cycle 1, ACCESS is cycles 2..1+N, and HOLD/ack is cycle 2+N. With N=2, ack is in cycle 4.
- Throughput: one transaction per N+3 cycles, including the mandatory IDLE cycle.
- The rdata for a read is valid in the HOLD cycle, the same cycle as ack, and stays valid afterwards.
- Reset asserted in any state:
  - At the next edge the FSM returns to IDLE and all reset values apply.
  - Any in-flight transaction is dropped with no ack.
  - A write cut short in ACCESS may leave the SRAM location undefined.
- If a request arrives while busy, it waits. It is not lost, provided req stays high.

## Structure
- Package sram_ctrl_pkg holds the state encoding (IDLE, SETUP, ACCESS, HOLD), ADDR_W and DATA_W, and the ACCESS counter width derived from ACCESS_CYCLES.
- Sub-module rr_arb2: combinational two-way round-robin grant from req0, req1 and last_grant.
- The FSM, latches and tristate driver live in sram_arbiter.

## Test plan
- Single write: port0 writes 5 to address 0.
  - sram_we is high for exactly 2 cycles, with sram_addr=0 and sram_data=5 stable from SETUP through HOLD.
  - ack0 pulses in cycle 4; ack1 stays 0.
- Write then read across ports: port1 writes 8 to address 1, then port0 reads address 1.
  - rdata0=8 when ack0 fires; rdata1 is unchanged at 0.
- Simultaneous requests right after reset: both ports request (port0 reads addr 0, port1 writes 6 to addr 1).
  - Port0 is served first, then port1.
  - A third simultaneous pair is served starting with port0 again (alternation).
- Overwrite: write 8 then 6 to address 1, then read address 1.
  - rdata returns 6; sram_data is Z during the read strobe.
- Reset mid-access: assert reset during the second ACCESS cycle of a write.
  - Next cycle: strobes 0, bus Z, busy=0, no ack.
  - A subsequent read of an untouched address (e.g., address 0 holding 5) returns 5.
- Parameter sweep: ACCESS_CYCLES=1 and 4.
  - The strobe width equals the parameter.
  - ack arrives at cycle 2+N.
